// File: rtl/mgmt_gpio_pulse_monitor_if.sv
// Control and status bundle between the pulse monitor and its controller/observer.
interface mgmt_gpio_pulse_monitor_if #(
    parameter int unsigned CNT_W = 24
);
    logic             enable;
    logic             clear;
    logic             gpio_in;
    logic             busy;
    logic             pass;
    logic             fail;
    logic [1:0]       fail_code;
    logic [7:0]       pulse_count;
    logic [CNT_W-1:0] last_high_width;
    logic [CNT_W-1:0] last_low_width;

    modport master (
        output enable,
        output clear,
        output gpio_in,
        input  busy,
        input  pass,
        input  fail,
        input  fail_code,
        input  pulse_count,
        input  last_high_width,
        input  last_low_width
    );

    modport slave (
        input  enable,
        input  clear,
        input  gpio_in,
        output busy,
        output pass,
        output fail,
        output fail_code,
        output pulse_count,
        output last_high_width,
        output last_low_width
    );
endinterface

// File: rtl/mgmt_gpio_pulse_monitor.sv
// Blink-count monitor for the management GPIO pad: synchronizes the pad,
// qualifies pulse widths, counts complete pulses and flags pass/glitch/timeout.
module mgmt_gpio_pulse_monitor #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_PULSES  = 10,
    parameter int unsigned MIN_WIDTH   = 4,
    parameter int unsigned TIMEOUT     = 100000,
    parameter int unsigned CNT_W       = 24
) (
    input  logic                    core_clk,
    input  logic                    core_rst,
    mgmt_gpio_pulse_monitor_if.slave mon
);
    localparam logic [7:0]       PULSE_TARGET = 8'(NUM_PULSES);
    localparam logic [CNT_W-1:0] WIDTH_MIN    = CNT_W'(MIN_WIDTH);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [1:0]       CODE_NONE    = 2'b00;
    localparam logic [1:0]       CODE_GLITCH  = 2'b01;
    localparam logic [1:0]       CODE_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   prime_q;
    logic                   gpio_s;
    logic                   gpio_d;
    logic                   primed;
    logic                   rise;
    logic                   fall;
    logic                   edge_seen;

    state_t                 state;
    logic [CNT_W-1:0]       width_q;
    logic [CNT_W-1:0]       tmo_q;
    logic [CNT_W-1:0]       width_inc;
    logic [CNT_W-1:0]       tmo_inc;
    logic                   tmo_hit;
    logic                   running;

    logic                   pass_q;
    logic                   fail_q;
    logic                   verdict;
    logic [1:0]             code_q;
    logic [7:0]             count_q;
    logic [7:0]             count_inc;
    logic [CNT_W-1:0]       high_q;
    logic [CNT_W-1:0]       low_q;

    // Pad synchronizer plus edge-detect flop; prime_q masks edges until the
    // chain holds real pad samples, so a pad high out of reset is not a rise.
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            sync_q  <= '0;
            gpio_d  <= 1'b0;
            prime_q <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], mon.gpio_in};
            gpio_d  <= gpio_s;
            prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign gpio_s    = sync_q[SYNC_STAGES-1];
    assign primed    = prime_q[SYNC_STAGES];
    assign rise      = primed & gpio_s & ~gpio_d;
    assign fall      = primed & ~gpio_s & gpio_d;
    assign edge_seen = rise | fall;

    assign width_inc = (&width_q) ? width_q : width_q + CNT_ONE;
    assign tmo_inc   = tmo_q + CNT_ONE;
    assign tmo_hit   = !edge_seen && (tmo_inc >= TIMEOUT_LIM);
    assign count_inc = count_q + 8'd1;
    assign running   = (state == S_ARMED) || (state == S_HIGH) || (state == S_LOW);
    assign verdict   = pass_q | fail_q;

    // Monitor FSM; a verdict, once recorded, is kept until clear or reset.
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state   <= S_IDLE;
            width_q <= '0;
            tmo_q   <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            code_q  <= CODE_NONE;
            count_q <= '0;
            high_q  <= '0;
            low_q   <= '0;
        end else if (mon.clear) begin
            state   <= S_IDLE;
            width_q <= '0;
            tmo_q   <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            code_q  <= CODE_NONE;
            count_q <= '0;
            high_q  <= '0;
            low_q   <= '0;
        end else if (!mon.enable) begin
            state   <= S_IDLE;
            width_q <= '0;
            tmo_q   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state   <= S_ARMED;
                    width_q <= '0;
                    tmo_q   <= '0;
                end
                S_ARMED: begin
                    if (rise) begin
                        state   <= S_HIGH;
                        width_q <= CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (fall) begin
                        if (width_q < WIDTH_MIN) begin
                            state <= S_DONE;
                            if (!verdict) begin
                                fail_q <= 1'b1;
                                code_q <= CODE_GLITCH;
                            end
                        end else begin
                            high_q  <= width_q;
                            count_q <= count_inc;
                            if (count_inc == PULSE_TARGET) begin
                                state <= S_DONE;
                                if (!verdict) begin
                                    pass_q <= 1'b1;
                                end
                            end else begin
                                state   <= S_LOW;
                                width_q <= CNT_ONE;
                            end
                        end
                    end else begin
                        width_q <= width_inc;
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        low_q   <= width_q;
                        state   <= S_HIGH;
                        width_q <= CNT_ONE;
                    end else begin
                        width_q <= width_inc;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Any edge restarts the inactivity window, even on the limit cycle.
            if (running) begin
                if (edge_seen) begin
                    tmo_q <= '0;
                end else if (tmo_hit) begin
                    state <= S_DONE;
                    tmo_q <= '0;
                    if (!verdict) begin
                        fail_q <= 1'b1;
                        code_q <= CODE_TIMEOUT;
                    end
                end else begin
                    tmo_q <= tmo_inc;
                end
            end
        end
    end

    assign mon.busy            = running;
    assign mon.pass            = pass_q;
    assign mon.fail            = fail_q;
    assign mon.fail_code       = code_q;
    assign mon.pulse_count     = count_q;
    assign mon.last_high_width = high_q;
    assign mon.last_low_width  = low_q;
endmodule

// File: tb/tb_mgmt_gpio_pulse_monitor.sv
// Scoreboard bench for the GPIO pulse monitor: directed pad waveforms queue
// expected verdicts, a negedge monitor checks them when pass/fail rises.
`timescale 1ns/1ps
module tb_mgmt_gpio_pulse_monitor;
    localparam int unsigned CNT_W = 24;
    localparam int unsigned TMO   = 1000;
    localparam int          LAT   = 3;

    logic core_clk = 1'b0;
    logic core_rst = 1'b1;
    always #5 core_clk = ~core_clk;

    mgmt_gpio_pulse_monitor_if #(.CNT_W(CNT_W)) mon_if ();

    mgmt_gpio_pulse_monitor #(
        .SYNC_STAGES(2),
        .NUM_PULSES (10),
        .MIN_WIDTH  (4),
        .TIMEOUT    (TMO),
        .CNT_W      (CNT_W)
    ) dut (
        .core_clk(core_clk),
        .core_rst(core_rst),
        .mon     (mon_if)
    );

    typedef struct {
        logic             pass;
        logic             fail;
        logic [1:0]       code;
        logic [7:0]       count;
        logic [CNT_W-1:0] hw;
        logic [CNT_W-1:0] lw;
        int               at;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge core_clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t mk(input logic p, input logic f, input logic [1:0] c,
                                input logic [7:0] n, input int hw, input int lw);
        exp_t e;
        e.pass  = p;
        e.fail  = f;
        e.code  = c;
        e.count = n;
        e.hw    = CNT_W'(hw);
        e.lw    = CNT_W'(lw);
        e.at    = 0;
        return e;
    endfunction

    // Verdict monitor: pops one expectation per rising pass|fail.
    logic prev_v = 1'b0;
    always @(negedge core_clk) begin
        logic v;
        exp_t e;
        v = mon_if.pass | mon_if.fail;
        if (v && !prev_v) begin
            if (exp_q.size() == 0) begin
                check("unexpected_verdict", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_pass",      mon_if.pass,            e.pass);
                check("sb_fail",      mon_if.fail,            e.fail);
                check("sb_fail_code", mon_if.fail_code,       e.code);
                check("sb_count",     mon_if.pulse_count,     e.count);
                check("sb_high_w",    mon_if.last_high_width, e.hw);
                check("sb_low_w",     mon_if.last_low_width,  e.lw);
                check("sb_cycle",     cyc,                    e.at);
            end
        end
        prev_v = v;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge core_clk);
    endtask

    task automatic pulse(input int h, input int l);
        mon_if.gpio_in = 1'b1;
        tick(h);
        mon_if.gpio_in = 1'b0;
        tick(l);
    endtask

    // Last pulse of a sequence: the verdict is expected lat cycles after the fall is driven.
    task automatic final_fall(input int h, input int l, input exp_t e, input int lat);
        mon_if.gpio_in = 1'b1;
        tick(h);
        e.at = cyc + lat;
        exp_q.push_back(e);
        mon_if.gpio_in = 1'b0;
        tick(l);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pass"},  mon_if.pass,            0);
        check({tag, "_fail"},  mon_if.fail,            0);
        check({tag, "_code"},  mon_if.fail_code,       0);
        check({tag, "_count"}, mon_if.pulse_count,     0);
        check({tag, "_hw"},    mon_if.last_high_width, 0);
        check({tag, "_lw"},    mon_if.last_low_width,  0);
        check({tag, "_busy"},  mon_if.busy,            0);
    endtask

    task automatic clear_pulse();
        mon_if.clear = 1'b1;
        tick(1);
        mon_if.clear = 1'b0;
    endtask

    initial begin
        mon_if.enable  = 1'b0;
        mon_if.clear   = 1'b0;
        mon_if.gpio_in = 1'b0;
        tick(3);
        check_zero("reset");
        core_rst = 1'b0;
        tick(2);

        // Ten clean pulses, high 20 / low 30
        mon_if.enable = 1'b1;
        tick(5);
        check("armed_busy", mon_if.busy, 1);
        repeat (9) pulse(20, 30);
        final_fall(20, 30, mk(1'b1, 1'b0, 2'b00, 8'd10, 20, 30), LAT);
        check("done_busy", mon_if.busy, 0);

        // Clear in DONE, then pass again at exactly the minimum high width
        clear_pulse();
        check_zero("clear");
        tick(1);
        check("rearm_busy", mon_if.busy, 1);
        repeat (9) pulse(4, 5);
        final_fall(4, 5, mk(1'b1, 1'b0, 2'b00, 8'd10, 4, 5), LAT);

        // enable low keeps the verdict and counts
        mon_if.enable = 1'b0;
        tick(3);
        check("disable_pass",  mon_if.pass,        1);
        check("disable_count", mon_if.pulse_count, 10);
        check("disable_busy",  mon_if.busy,        0);
        clear_pulse();
        mon_if.enable = 1'b1;
        tick(2);

        // Third high phase is a 2-cycle glitch
        repeat (2) pulse(6, 10);
        final_fall(2, 10, mk(1'b0, 1'b1, 2'b01, 8'd2, 6, 10), LAT);
        repeat (3) pulse(6, 10);
        check("glitch_hold_count", mon_if.pulse_count,     2);
        check("glitch_hold_code",  mon_if.fail_code,       1);
        check("glitch_hold_pass",  mon_if.pass,            0);
        check("glitch_hold_hw",    mon_if.last_high_width, 6);
        check("glitch_hold_busy",  mon_if.busy,            0);

        // Pad stuck low after 5 pulses
        clear_pulse();
        tick(2);
        repeat (4) pulse(10, 10);
        final_fall(10, TMO + 20, mk(1'b0, 1'b1, 2'b10, 8'd5, 10, 10), LAT + TMO);
        check("timeout_count", mon_if.pulse_count, 5);
        check("timeout_code",  mon_if.fail_code,   2);

        // Pad already high when enable rises
        mon_if.enable = 1'b0;
        clear_pulse();
        mon_if.gpio_in = 1'b1;
        tick(5);
        mon_if.enable = 1'b1;
        tick(20);
        check("prehigh_busy",  mon_if.busy,        1);
        check("prehigh_count", mon_if.pulse_count, 0);
        mon_if.gpio_in = 1'b0;
        tick(10);
        check("prehigh_fall_count", mon_if.pulse_count, 0);
        repeat (9) pulse(15, 25);
        final_fall(15, 25, mk(1'b1, 1'b0, 2'b00, 8'd10, 15, 25), LAT);

        // Asynchronous reset during the 4th high phase
        clear_pulse();
        tick(2);
        repeat (3) pulse(10, 10);
        mon_if.gpio_in = 1'b1;
        tick(5);
        check("pre_rst_count", mon_if.pulse_count, 3);
        core_rst = 1'b1;
        #1;
        check_zero("async_rst");
        tick(3);
        core_rst = 1'b0;
        tick(10);
        check("post_rst_busy",  mon_if.busy,        1);
        check("post_rst_count", mon_if.pulse_count, 0);
        mon_if.gpio_in = 1'b0;
        tick(10);
        repeat (9) pulse(12, 14);
        final_fall(12, 14, mk(1'b1, 1'b0, 2'b00, 8'd10, 12, 14), LAT);

        tick(5);
        check("pending_verdicts", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
